// File: rtl/hazard_scoreboard.sv
// Producer-side hazard tracker: records registers with unforwardable in-flight writes
// (loads, CSR reads) and stalls the decode instruction until MEM/WB forwarding can supply them.
module hazard_scoreboard #(
   parameter int STALL_TIMEOUT = 1023,
   parameter int CNT_W         = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_id_valid,
   input  logic             i_flush,
   input  logic [4:0]       i_rs1_addr_id,
   input  logic [4:0]       i_rs2_addr_id,
   input  logic             i_rs1_used_id,
   input  logic             i_rs2_used_id,
   input  logic [4:0]       i_rd_addr_id,
   input  logic             i_rd_wr_en_id,
   input  logic             i_long_id,
   input  logic             i_mem_long,
   input  logic             i_mem_ready,
   input  logic [4:0]       i_rd_addr_mem,
   output logic             o_stall,
   output logic [31:0]      o_pending,
   output logic [CNT_W-1:0] o_stall_count,
   output logic             o_deadlock
);

   logic [31:0]      r_pending;
   logic [15:0]      r_run_cnt;
   logic [CNT_W-1:0] r_stall_count;
   logic             r_deadlock;

   logic [31:0] w_clr;
   logic [31:0] w_set;
   logic [31:0] w_eff;
   logic        w_raw1;
   logic        w_raw2;
   logic        w_waw;
   logic        w_stall;
   logic        w_issue;
   logic [15:0] w_run_next;

   // NOTE: every always_comb output gets a default before any conditional write,
   // otherwise the untaken path holds its old value and a latch is inferred.
   always_comb begin
      w_clr = '0;
      if (i_mem_long && i_mem_ready)
         w_clr[i_rd_addr_mem] = 1'b1;
   end

   // A producer finishing MEM this cycle is forwardable from WB next cycle.
   assign w_eff = r_pending & ~w_clr;

   assign w_raw1  = i_rs1_used_id && (i_rs1_addr_id != 5'd0) && w_eff[i_rs1_addr_id];
   assign w_raw2  = i_rs2_used_id && (i_rs2_addr_id != 5'd0) && w_eff[i_rs2_addr_id];
   assign w_waw   = i_rd_wr_en_id && (i_rd_addr_id  != 5'd0) && w_eff[i_rd_addr_id];
   assign w_stall = i_id_valid && !i_flush && (w_raw1 || w_raw2 || w_waw);
   assign w_issue = i_id_valid && !i_flush && !w_stall;

   always_comb begin
      w_set = '0;
      if (w_issue && i_long_id && i_rd_wr_en_id && (i_rd_addr_id != 5'd0))
         w_set[i_rd_addr_id] = 1'b1;
   end

   always_comb begin
      w_run_next = '0;
      if (w_stall)
         w_run_next = (r_run_cnt == 16'hFFFF) ? r_run_cnt : r_run_cnt + 16'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pending     <= '0;
         r_run_cnt     <= '0;
         r_stall_count <= '0;
         r_deadlock    <= 1'b0;
      end else begin
         // Set is OR-ed after the clear so a same-register set wins.
         r_pending <= w_eff | w_set;
         r_run_cnt <= w_run_next;
         if (w_stall && (r_stall_count != '1))
            r_stall_count <= r_stall_count + CNT_W'(1);
         if (w_stall && (int'(w_run_next) == STALL_TIMEOUT))
            r_deadlock <= 1'b1;
      end
   end

   assign o_stall       = w_stall;
   assign o_pending     = r_pending;
   assign o_stall_count = r_stall_count;
   assign o_deadlock    = r_deadlock;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus pushes hand-computed expectations into a
// queue; a negedge monitor pops one per cycle and compares against the DUT outputs.
module tb_hazard_scoreboard;

   typedef struct packed {
      logic        stall;
      logic [31:0] pend;
      logic [31:0] cnt;
      logic        dl;
   } obs_t;

   typedef struct {
      int   cyc;
      obs_t exp;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0, flush = 1'b0;
   logic [4:0]  rs1 = '0, rs2 = '0, rd = '0, rd_mem = '0;
   logic        rs1_used = 1'b0, rs2_used = 1'b0, rd_wr = 1'b0, long_id = 1'b0;
   logic        mem_long = 1'b0, mem_ready = 1'b0;
   logic        stall, deadlock;
   logic [31:0] pending, stall_count;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc_no   = 0;

   hazard_scoreboard #(.STALL_TIMEOUT(8), .CNT_W(32)) dut (
      .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid), .i_flush(flush),
      .i_rs1_addr_id(rs1), .i_rs2_addr_id(rs2),
      .i_rs1_used_id(rs1_used), .i_rs2_used_id(rs2_used),
      .i_rd_addr_id(rd), .i_rd_wr_en_id(rd_wr), .i_long_id(long_id),
      .i_mem_long(mem_long), .i_mem_ready(mem_ready), .i_rd_addr_mem(rd_mem),
      .o_stall(stall), .o_pending(pending), .o_stall_count(stall_count),
      .o_deadlock(deadlock)
   );

   always #5 clk = ~clk;

   task automatic check(input int cyc, input obs_t got, input obs_t exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL cyc%0d: got stall=%0b pend=%h cnt=%0d dl=%0b, expected stall=%0b pend=%h cnt=%0d dl=%0b",
                  cyc, got.stall, got.pend, got.cnt, got.dl, exp.stall, exp.pend, exp.cnt, exp.dl);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check(e.cyc, '{stall: stall, pend: pending, cnt: stall_count, dl: deadlock}, e.exp);
      end
   end

   // flags = {rs1_used, rs2_used, rd_wr, long}; mem = {mem_long, mem_ready}
   task automatic cyc(input logic r, input logic v, input logic f,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] ad,
                      input logic [3:0] flags, input logic [1:0] mem, input logic [4:0] am,
                      input logic e_stall, input logic [31:0] e_pend,
                      input logic [31:0] e_cnt, input logic e_dl);
      exp_t e;
      @(posedge clk);
      #1;
      id_valid = v; flush = f;
      rs1 = a1; rs2 = a2; rd = ad;
      {rs1_used, rs2_used, rd_wr, long_id} = flags;
      {mem_long, mem_ready} = mem;
      rd_mem = am;
      rst = r;
      e.cyc = cyc_no;
      e.exp = '{stall: e_stall, pend: e_pend, cnt: e_cnt, dl: e_dl};
      exp_q.push_back(e);
      cyc_no++;
   endtask

   task automatic idle(input logic r, input logic [1:0] mem, input logic [4:0] am,
                       input logic [31:0] e_pend, input logic [31:0] e_cnt, input logic e_dl);
      cyc(r, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 4'b0000, mem, am, 1'b0, e_pend, e_cnt, e_dl);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      idle(1'b1, 2'b00, 5'd0, 32'h0, 0, 1'b0);
      idle(1'b0, 2'b00, 5'd0, 32'h0, 0, 1'b0);
      // Load-use: lw x5 ; add x6,x5,x1 stalls one cycle, drops when x5 completes MEM
      cyc(0, 1, 0, 5'd0, 5'd0, 5'd5, 4'b0011, 2'b00, 5'd0, 0, 32'h0,  0, 0);
      cyc(0, 1, 0, 5'd5, 5'd1, 5'd6, 4'b1110, 2'b00, 5'd0, 1, 32'h20, 0, 0);
      cyc(0, 1, 0, 5'd5, 5'd1, 5'd6, 4'b1110, 2'b11, 5'd5, 0, 32'h20, 1, 0);
      idle(0, 2'b00, 5'd0, 32'h0, 1, 0);
      // x0 destination and x0 sources never stall or set
      cyc(0, 1, 0, 5'd0, 5'd0, 5'd0, 4'b0011, 2'b00, 5'd0, 0, 32'h0, 1, 0);
      cyc(0, 1, 0, 5'd0, 5'd0, 5'd0, 4'b1100, 2'b00, 5'd0, 0, 32'h0, 1, 0);
      // Unused rs2 reading pending x9
      cyc(0, 1, 0, 5'd0, 5'd0, 5'd9,  4'b0011, 2'b00, 5'd0, 0, 32'h0,   1, 0);
      cyc(0, 1, 0, 5'd1, 5'd9, 5'd10, 4'b1010, 2'b00, 5'd0, 0, 32'h200, 1, 0);
      // Flush: lw x11,0(x9) killed -> no stall, no set; then stalls, then issues as x9 clears
      cyc(0, 1, 1, 5'd9, 5'd0, 5'd11, 4'b1011, 2'b00, 5'd0, 0, 32'h200, 1, 0);
      cyc(0, 1, 0, 5'd9, 5'd0, 5'd11, 4'b1011, 2'b00, 5'd0, 1, 32'h200, 1, 0);
      cyc(0, 1, 0, 5'd9, 5'd0, 5'd11, 4'b1011, 2'b11, 5'd9, 0, 32'h200, 2, 0);
      idle(0, 2'b11, 5'd11, 32'h800, 2, 0);
      // Memory wait + WAW on x7: four stall cycles, then set wins over clear
      cyc(0, 1, 0, 5'd0, 5'd0, 5'd7, 4'b0011, 2'b00, 5'd0, 0, 32'h0,  2, 0);
      cyc(0, 1, 0, 5'd2, 5'd0, 5'd7, 4'b1011, 2'b00, 5'd0, 1, 32'h80, 2, 0);
      cyc(0, 1, 0, 5'd2, 5'd0, 5'd7, 4'b1011, 2'b10, 5'd7, 1, 32'h80, 3, 0);
      cyc(0, 1, 0, 5'd2, 5'd0, 5'd7, 4'b1011, 2'b10, 5'd7, 1, 32'h80, 4, 0);
      cyc(0, 1, 0, 5'd2, 5'd0, 5'd7, 4'b1011, 2'b10, 5'd7, 1, 32'h80, 5, 0);
      cyc(0, 1, 0, 5'd2, 5'd0, 5'd7, 4'b1011, 2'b11, 5'd7, 0, 32'h80, 6, 0);
      idle(0, 2'b11, 5'd7, 32'h80, 6, 0);
      // Back-to-back long ops x5, x7 then a consumer of both; async reset mid-stall
      cyc(0, 1, 0, 5'd0, 5'd0, 5'd5, 4'b0011, 2'b00, 5'd0, 0, 32'h0,  6, 0);
      cyc(0, 1, 0, 5'd0, 5'd0, 5'd7, 4'b0011, 2'b00, 5'd0, 0, 32'h20, 6, 0);
      cyc(0, 1, 0, 5'd7, 5'd5, 5'd8, 4'b1110, 2'b00, 5'd0, 1, 32'hA0, 6, 0);
      cyc(1, 1, 0, 5'd7, 5'd5, 5'd8, 4'b1110, 2'b00, 5'd0, 0, 32'h0,  0, 0);
      idle(0, 2'b00, 5'd0, 32'h0, 0, 0);
      // Watchdog: eight consecutive stalls on x3 set the sticky flag
      cyc(0, 1, 0, 5'd0, 5'd0, 5'd3, 4'b0011, 2'b00, 5'd0, 0, 32'h0, 0, 0);
      for (int k = 0; k < 8; k++)
         cyc(0, 1, 0, 5'd3, 5'd0, 5'd4, 4'b1010, 2'b10, 5'd3, 1, 32'h8, k, 0);
      cyc(0, 1, 0, 5'd3, 5'd0, 5'd4, 4'b1010, 2'b11, 5'd3, 0, 32'h8, 8, 1);
      idle(0, 2'b00, 5'd0, 32'h0, 8, 1);
      idle(1, 2'b00, 5'd0, 32'h0, 0, 0);
      idle(0, 2'b00, 5'd0, 32'h0, 0, 0);

      repeat (2) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Load-use and long-latency hazard tracker for the RV32I_Zicsr five-stage pipeline; the producer-side counterpart of the EX-stage forwarding unit. It records which architectural registers have an in-flight write whose value cannot yet be forwarded (loads, CSR reads), and stalls the decode-stage instruction until forwarding from MEM/WB can satisfy it. It sits beside the ID/EX pipeline register, driving the ID/IF stall and the EX bubble insert. It also keeps a saturating stall-cycle counter and a sticky deadlock watchdog.

## Interface

Parameters:
- `STALL_TIMEOUT`, default 1023: consecutive stall cycles that set `o_deadlock`.
- `CNT_W`, default 32: width of `o_stall_count`.

Ports:
- `i_clk`, in, 1: clock, rising edge.
- `i_rst`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `i_id_valid`, in, 1: decode stage holds a valid instruction.
- `i_flush`, in, 1: decode instruction is being killed (branch/trap) this cycle.
- `i_rs1_addr_id` / `i_rs2_addr_id`, in, `XADDR` each: source register addresses in ID.
- `i_rs1_used_id` / `i_rs2_used_id`, in, 1 each: the instruction reads that source.
- `i_rd_addr_id`, in, `XADDR`: destination address in ID.
- `i_rd_wr_en_id`, in, 1: the ID instruction writes `rd`.
- `i_long_id`, in, 1: the ID instruction's result is not available until the end of MEM (load, CSR read).
- `i_mem_long`, in, 1: the MEM stage holds a long-latency producer.
- `i_mem_ready`, in, 1: MEM data is valid this cycle.
- `i_rd_addr_mem`, in, `XADDR`: destination address in MEM.
- `o_stall`, out, 1: hold IF/ID and insert a bubble into EX.
- `o_pending`, out, 32: pending bitmap (debug).
- `o_stall_count`, out, `CNT_W`: saturating count of stall cycles.
- `o_deadlock`, out, 1: sticky watchdog flag.

## Operation

- **State:**
  - `pending[31:0]`: one bit per register. Bit 0 is never set.
  - Consecutive-stall counter `run_cnt`: 16 bits, saturating.
  - `o_stall_count`.
  - `o_deadlock`.
- **Clear mask:** `clr = (i_mem_long && i_mem_ready) ? onehot(i_rd_addr_mem) : 0`.
- **Effective pending:** `eff = pending & ~clr`. A register whose producer completes MEM this cycle is treated as forwardable from WB next cycle.
- **Stall:** `o_stall = i_id_valid && !i_flush && (raw1 || raw2 || waw)`, where:
  - `rawN = i_rsN_used_id && rsN != 0 && eff[rsN]`
  - `waw = i_rd_wr_en_id && rd != 0 && eff[rd]`
  - The WAW stall guarantees at most one pending producer per register.
- **Issue:** `issue = i_id_valid && !i_flush && !o_stall`.
  - If `issue && i_long_id && i_rd_wr_en_id && rd != 0`, the set bit for `rd` is 1.
- **Next state:** `pending_next = (pending & ~clr) | set`. When set and clear hit the same register in the same cycle, set wins.
- **Short ops:** never touch `pending`. EX/MEM/WB forwarding covers them.
- **Stall counter:** `o_stall_count` increments when `o_stall` is 1 and saturates at all-ones.
- **Watchdog:**
  - `run_cnt` increments while `o_stall` is 1 and returns to 0 when `o_stall` is 0.
  - When `run_cnt == STALL_TIMEOUT`, `o_deadlock` is set to 1 and stays set until reset.
- **Flush:** `i_flush` only suppresses stall and issue for the ID instruction. Already-issued producers are never cancelled, because EX onward always completes.

## Timing

- **Reset:** while `i_rst` is high, immediately and asynchronously:
  - `pending = 0`
  - `o_pending = 0`
  - `o_stall_count = 0`
  - `run_cnt = 0`
  - `o_deadlock = 0`
  - `o_stall = 0` (combinational, follows from `pending = 0`).
- **Output paths:**
  - `o_stall` is combinational from current inputs and registered `pending`. There is no registered delay.
  - `o_pending` is the register output and updates one edge after the set or clear.
- **Load-use penalty:**
  - Edge t: the load issues.
  - Cycle t+1: the load is in EX and a dependent instruction in ID stalls.
  - Cycle t+2: the load is in MEM with `i_mem_ready=1`; the stall drops and the dependent instruction issues.
  - The penalty is exactly one bubble.
- **Memory wait:** if `i_mem_ready` is held low, the stall lasts for each extra cycle.
- **Back-to-back long ops to different registers:** both bits are pending simultaneously.
- **Reset mid-stall:** all state clears and `o_stall` drops in the same cycle `i_rst` is asserted.

## Test plan

- **Load-use:** load x5 issues, then `add x6,x5,x1` in ID.
  - `o_stall` = 1 for exactly one cycle, drops in the cycle `i_mem_long=1`, `i_rd_addr_mem=5`, `i_mem_ready=1`.
  - `pending[5]` clears at the next edge.
  - `o_stall_count` = 1.
- **x0 and unused sources:** load to x0, then consumer of x0 → no stall and `o_pending` stays 0. A consumer with `i_rs2_used_id=0` reading a pending register → no stall.
- **Memory wait + WAW:** load x7 with `i_mem_ready` low for 3 MEM cycles while ID holds `lw x7` (WAW).
  - Stall lasts 4 cycles.
  - The second load issues the same cycle the first clears; `pending[7]` remains 1 (set wins).
- **Flush:** dependent instruction in ID with `i_flush=1` → `o_stall` = 0, no issue, `pending` unchanged.
- **Watchdog:** `STALL_TIMEOUT=8`, hold `i_mem_ready=0` with a dependent instruction in ID.
  - `o_deadlock` rises after the 8th consecutive stall cycle.
  - It stays 1 after the stall clears and returns to 0 only on `i_rst`.
- **Async reset:** with `pending=0x0000_00A0` and stall active, assert `i_rst` between edges → `o_pending=0`, `o_stall=0`, counters 0 before the next edge.
